ex_muldiv: RTL

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/mips_defs.sv | 17 +
 rtl/ex_muldiv.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mips_defs.sv
// Shared MIPS execution-unit definitions: HI/LO unit op codes and FSM states.
package mips_defs;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// One shift-add or restoring-divide step per falling clock edge.
module ex_muldiv
    import mips_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic            kill,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done,
    output logic            stall
);

    localparam int PW = 2 * XLEN;
    localparam int CW = $clog2(XLEN);

    md_state_e       state, state_nxt;
    md_op_e          op_q;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] a_q, opnd, sreg;
    logic [PW-1:0]   acc, acc_step, prod;
    logic            neg_res, neg_rem, div0;
    logic            accept, last, is_div;
    logic            sgn_a, sgn_b, signed_op;
    logic [XLEN:0]   madd, trial;
    logic [XLEN-1:0] res_hi, res_lo;

    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [PW-1:0] cneg_wide(input logic [PW-1:0] v, input logic n);
        return n ? (~v + PW'(1)) : v;
    endfunction

    assign accept    = (state == ST_IDLE) && start && !kill;
    assign last      = (cnt == CW'(XLEN - 1));
    assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign signed_op = !op[0];
    assign sgn_a     = signed_op && src_a[XLEN-1];
    assign sgn_b     = signed_op && src_b[XLEN-1];

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        stall     = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = start && !kill;
                if (accept) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy  = 1'b1;
                stall = 1'b1;
                if (kill)      state_nxt = ST_IDLE;
                else if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // One iteration: multiply adds the multiplicand into the upper half and shifts
    // right; divide shifts the remainder/quotient pair left and tries a subtract.
    always_comb begin
        madd  = {1'b0, acc[PW-1:XLEN]} + {1'b0, (sreg[0] ? opnd : '0)};
        trial = acc[PW-1:XLEN-1] - {1'b0, opnd};
        if (is_div)
            acc_step = trial[XLEN] ? {acc[PW-2:0], 1'b0}
                                   : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_step = {madd, acc[XLEN-1:1]};
    end

    always_comb begin
        prod   = cneg_wide(acc_step, neg_res);
        res_hi = prod[PW-1:XLEN];
        res_lo = prod[XLEN-1:0];
        if (is_div) begin
            if (div0) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                res_hi = cneg(acc_step[PW-1:XLEN], neg_rem);
                res_lo = cneg(acc_step[XLEN-1:0], neg_res);
            end
        end
    end

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q    <= OP_MULT;
            cnt     <= '0;
            a_q     <= '0;
            opnd    <= '0;
            sreg    <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (accept) begin
            op_q    <= md_op_e'(op);
            cnt     <= '0;
            a_q     <= src_a;
            sreg    <= cneg(src_b, sgn_b);
            neg_res <= sgn_a ^ sgn_b;
            neg_rem <= sgn_a;
            div0    <= (src_b == '0);
            if (op[1]) begin
                opnd <= cneg(src_b, sgn_b);
                acc  <= {{XLEN{1'b0}}, cneg(src_a, sgn_a)};
            end else begin
                opnd <= cneg(src_a, sgn_a);
                acc  <= '0;
            end
        end else if (state == ST_RUN && !kill) begin
            acc  <= acc_step;
            sreg <= sreg >> 1;
            cnt  <= cnt + CW'(1);
            if (last) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (state == ST_IDLE) begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
        end
    end

endmodule
